// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer controller.
//   state_t    : 3-bit state code driven onto the state output
//   LFSR_TAPS  : feedback mask for the 16-bit delay LFSR (taps 16,14,13,11)
//   BCD_MAX    : largest legal BCD digit
//   lfsr_next  : one shift of the delay LFSR
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_TIMING = 3'd2,
    S_SHOW   = 3'd3,
    S_EARLY  = 3'd4
  } state_t;

  // Tap n maps to bit n-1 of the shift register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  BCD_MAX   = 4'd9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Button/display bundle of the reaction timer.
//   start, react : single-cycle pulses from the debounced buttons
//   led, early   : cue LED and false-start flag
//   state        : current state code
//   ones..thousandths : BCD result digits for the segment decoder
// slave  : the controller side (buttons in, display out)
// master : the driver/observer side
interface reaction_timer_ctrl_if;
  import reaction_pkg::*;

  logic       start;
  logic       react;
  logic       led;
  logic       early;
  state_t     state;
  logic [3:0] ones;
  logic [3:0] tenths;
  logic [3:0] hundredths;
  logic [3:0] thousandths;

  modport slave (
    input  start, react,
    output led, early, state, ones, tenths, hundredths, thousandths
  );

  modport master (
    output start, react,
    input  led, early, state, ones, tenths, hundredths, thousandths
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit cascaded BCD counter, saturating at 9999.
//   clk, reset_n : clock and synchronous active-low reset
//   clr          : synchronous clear to 0000 (wins over en)
//   en           : advance by one count
//   ones..thousandths : registered BCD digits, most to least significant
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] ones,
  output logic [3:0] tenths,
  output logic [3:0] hundredths,
  output logic [3:0] thousandths
);

  // dig[0] is the least significant digit.
  logic [3:0] dig     [4];
  logic [3:0] dig_nxt [4];
  logic       sat;

  assign sat = (dig[0] == BCD_MAX) && (dig[1] == BCD_MAX) &&
               (dig[2] == BCD_MAX) && (dig[3] == BCD_MAX);

  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig_nxt[i] = dig[i];
      if (carry) begin
        if (dig[i] == BCD_MAX) begin
          dig_nxt[i] = 4'd0;
        end else begin
          dig_nxt[i] = dig[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else if (en && !sat) begin
      for (int i = 0; i < 4; i++) dig[i] <= dig_nxt[i];
    end
  end

  assign thousandths = dig[0];
  assign hundredths  = dig[1];
  assign tenths      = dig[2];
  assign ones        = dig[3];

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time measurement sequencer.
// After start it waits WAIT_BASE_MS plus a pseudo-random 0..1023 ms, lights
// the cue LED, counts milliseconds in BCD until react, then freezes the result.
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : start/react pulses in; led, early, state and BCD digits out
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | after reset, digits hold, waiting for start
//   S_WAIT   | random delay running, counted down in ms ticks
//   S_TIMING | cue lit, counting ms until react
//   S_SHOW   | result frozen on the digits
//   S_EARLY  | react came before the cue, digits forced to 0
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int          TICK_DIV     = 50000,
  parameter int          WAIT_BASE_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reaction_timer_ctrl_if.slave bus
);

  localparam int             PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_nxt;
  logic [PW-1:0] presc_q;
  logic [10:0]   delay_q;
  logic [15:0]   lfsr_q;
  logic          led_q, early_q;

  logic tick;
  logic load_delay, dec_delay, clr_dig, cnt_en, presc_clr;

  assign tick = (presc_q == PRE_LAST);

  always_comb begin
    state_nxt  = state_q;
    load_delay = 1'b0;
    dec_delay  = 1'b0;
    clr_dig    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (bus.start) begin
          state_nxt  = S_WAIT;
          load_delay = 1'b1;
          clr_dig    = 1'b1;
        end
      end
      S_EARLY: begin
        clr_dig = 1'b1;
        if (bus.start) begin
          state_nxt  = S_WAIT;
          load_delay = 1'b1;
        end
      end
      S_WAIT: begin
        // react beats an expiring tick in the same cycle
        if (bus.react) begin
          state_nxt = S_EARLY;
          clr_dig   = 1'b1;
        end else if (tick) begin
          if (delay_q == 11'd1) state_nxt = S_TIMING;
          else                  dec_delay = 1'b1;
        end
      end
      S_TIMING: begin
        // a tick coinciding with react is not counted
        if (bus.react)  state_nxt = S_SHOW;
        else if (tick)  cnt_en    = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restart the ms grid on entry so the first tick is a full period away.
  assign presc_clr = (state_nxt != state_q) &&
                     ((state_nxt == S_WAIT) || (state_nxt == S_TIMING));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      delay_q <= '0;
      lfsr_q  <= LFSR_SEED;
      led_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      lfsr_q  <= lfsr_next(lfsr_q);
      if (presc_clr || tick) presc_q <= '0;
      else                   presc_q <= presc_q + PW'(1);
      if (load_delay)     delay_q <= 11'(WAIT_BASE_MS) + {1'b0, lfsr_q[9:0]};
      else if (dec_delay) delay_q <= delay_q - 11'd1;
      led_q   <= (state_nxt == S_TIMING);
      early_q <= (state_nxt == S_EARLY);
    end
  end

  bcd_counter4 u_cnt (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr_dig),
    .en          (cnt_en),
    .ones        (bus.ones),
    .tenths      (bus.tenths),
    .hundredths  (bus.hundredths),
    .thousandths (bus.thousandths)
  );

  assign bus.state = state_q;
  assign bus.led   = led_q;
  assign bus.early = early_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed/randomized bench for reaction_timer_ctrl with small timing params.
module tb_reaction_timer_ctrl;
  import reaction_pkg::*;

  localparam int          TD   = 4;
  localparam int          WB   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reaction_timer_ctrl_if bus ();

  reaction_timer_ctrl #(
    .TICK_DIV     (TD),
    .WAIT_BASE_MS (WB),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, stepping every clock.
  logic [15:0] lfsr_m;
  always @(posedge clk) begin
    if (!reset_n) lfsr_m <= SEED;
    else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected display for a count of n ms, saturated at 9.999 s.
  function automatic logic [31:0] bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {16'h0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [31:0] digits();
    return {16'h0, bus.ones, bus.tenths, bus.hundredths, bus.thousandths};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start (optionally with react) and return the delay the DUT loads.
  task automatic start_run(input bit with_react, output int d);
    bus.start = 1'b1;
    bus.react = with_react;
    d = WB + int'(lfsr_m[9:0]);
    step();
    bus.start = 1'b0;
    bus.react = 1'b0;
  endtask

  // Called just after the edge entering WAIT; ends just after entering TIMING.
  task automatic wait_phase(input int d, input bit glitch);
    int g;
    g = glitch ? int'($urandom_range(1, 4 * d - 2)) : -1;
    for (int i = 1; i < 4 * d; i++) begin
      bus.start = (i == g);
      step();
    end
    bus.start = 1'b0;
    chk("wait_hold", 32'(bus.state), 32'(S_WAIT));
    step();
    chk("enter_timing", 32'(bus.state), 32'(S_TIMING));
    chk("led_on", 32'(bus.led), 32'd1);
  endtask

  // Let n ticks count, then react off (1..4) cycles later; off=4 coincides with tick n+1.
  task automatic timing_phase(input int n, input int off);
    step(4 * n);
    chk("count", digits(), bcd(n));
    step(off - 1);
    bus.react = 1'b1;
    step();
    bus.react = 1'b0;
    chk("show_state", 32'(bus.state), 32'(S_SHOW));
    chk("show_led", 32'(bus.led), 32'd0);
    chk("show_digits", digits(), bcd(n));
  endtask

  initial begin
    int d;
    int n;
    int off;
    bus.start = 1'b0;
    bus.react = 1'b0;

    // 1. reset and idle
    step(2);
    reset_n = 1'b1;
    chk("rst_state", 32'(bus.state), 32'(S_IDLE));
    chk("rst_digits", digits(), 32'h0);
    chk("rst_led", 32'(bus.led), 32'd0);
    chk("rst_early", 32'(bus.early), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(25);
      chk("idle_state", 32'(bus.state), 32'(S_IDLE));
      chk("idle_digits", digits(), 32'h0);
    end

    // 2. normal run, 1.234 s, held
    start_run(1'b0, d);
    chk("start_wait", 32'(bus.state), 32'(S_WAIT));
    chk("wait_led", 32'(bus.led), 32'd0);
    wait_phase(d, 1'b0);
    timing_phase(1234, 1);
    for (int k = 0; k < 10; k++) begin
      step(100);
      chk("hold_digits", digits(), bcd(1234));
      chk("hold_state", 32'(bus.state), 32'(S_SHOW));
    end

    // 3. false start from SHOW, then start+react together in EARLY
    start_run(1'b0, d);
    chk("fs_wait", 32'(bus.state), 32'(S_WAIT));
    chk("fs_clear", digits(), 32'h0);
    step(2);
    bus.react = 1'b1;
    step();
    bus.react = 1'b0;
    chk("early_state", 32'(bus.state), 32'(S_EARLY));
    chk("early_flag", 32'(bus.early), 32'd1);
    chk("early_digits", digits(), 32'h0);
    start_run(1'b1, d);
    chk("early_restart", 32'(bus.state), 32'(S_WAIT));
    chk("early_cleared", 32'(bus.early), 32'd0);

    // 4. saturation with a stray start during TIMING
    wait_phase(d, 1'b1);
    step(400);
    chk("sat_100", digits(), bcd(100));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step(4 * 9898 - 1);
    chk("sat_9998", digits(), bcd(9998));
    step(4);
    chk("sat_9999", digits(), bcd(9999));
    step(4 * 51);
    chk("sat_hold", digits(), bcd(9999));
    chk("sat_state", 32'(bus.state), 32'(S_TIMING));
    bus.react = 1'b1;
    step();
    bus.react = 1'b0;
    chk("sat_show", 32'(bus.state), 32'(S_SHOW));
    chk("sat_result", digits(), bcd(9999));

    // 5. start+react together in SHOW, then react coincident with 5th tick
    start_run(1'b1, d);
    chk("show_restart", 32'(bus.state), 32'(S_WAIT));
    chk("show_clear", digits(), 32'h0);
    wait_phase(d, 1'b0);
    timing_phase(4, 4);

    // 6. reset in the middle of TIMING
    start_run(1'b0, d);
    wait_phase(d, 1'b0);
    step(4 * 567);
    chk("mid_567", digits(), bcd(567));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_state", 32'(bus.state), 32'(S_IDLE));
    chk("mid_digits", digits(), 32'h0);
    chk("mid_led", 32'(bus.led), 32'd0);
    chk("mid_early", 32'(bus.early), 32'd0);

    // react alone in IDLE is ignored
    bus.react = 1'b1;
    step();
    bus.react = 1'b0;
    chk("idle_react", 32'(bus.state), 32'(S_IDLE));

    // randomized runs; delay after reset relies on the LFSR reload
    for (int r = 0; r < 2; r++) begin
      step($urandom_range(0, 50));
      start_run(r == 0, d);
      chk("rnd_wait", 32'(bus.state), 32'(S_WAIT));
      wait_phase(d, 1'b1);
      n   = $urandom_range(1, 300);
      off = $urandom_range(1, 4);
      timing_phase(n, off);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
